// File: rtl/reg_writeback_pkg.sv
// Shared types for the register writeback queue: register index width,
// queue entry control fields and head FSM states.
package reg_writeback_pkg;

   localparam int REG_IDX_W = 5;

   // Control half of a queue entry; the XLEN-wide data word sits in a
   // parallel array inside wb_fifo so this type stays width-independent.
   typedef struct packed {
      logic [REG_IDX_W-1:0] rd;
      logic                 reg_write;
      logic                 mem_to_reg;
      logic                 done;
   } wb_entry_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT_MEM,
      ST_WRITE
   } wb_state_e;

endpackage

// File: rtl/wb_fifo.sv
// In-order writeback queue: push at tail, pop at head, and in-order load
// completion into the oldest entry still waiting for memory data.
module wb_fifo
   import reg_writeback_pkg::*;
#(
   parameter int XLEN  = 64,
   parameter int DEPTH = 2
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       push,
   input  wb_entry_t                  push_entry,
   input  logic [XLEN-1:0]            push_data,
   input  logic                       pop,
   input  logic                       fill,
   input  logic [XLEN-1:0]            fill_data,
   output logic [$clog2(DEPTH):0]     cnt,
   output logic [REG_IDX_W-1:0]       head_rd,
   output logic                       head_reg_write,
   output logic [XLEN-1:0]            head_data,
   output logic                       next_done,
   output logic                       pend_any,
   output logic [$clog2(DEPTH)-1:0]   pend_off
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   wb_entry_t        ent [DEPTH];
   logic [XLEN-1:0]  dat [DEPTH];
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] fill_idx;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         cnt <= cnt + CNT_W'(push) - CNT_W'(pop);
      end
   end

   // Push targets a free slot and fill an occupied one, so they never collide.
   always_ff @(posedge clk) begin
      if (push) begin
         ent[wr_ptr] <= push_entry;
         dat[wr_ptr] <= push_data;
      end
      if (fill) begin
         ent[fill_idx].done <= 1'b1;
         dat[fill_idx]      <= fill_data;
      end
   end

   always_comb begin
      pend_any = 1'b0;
      pend_off = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if ((CNT_W'(i) < cnt) && ent[rd_ptr + PTR_W'(i)].mem_to_reg &&
             !ent[rd_ptr + PTR_W'(i)].done) begin
            pend_any = 1'b1;
            pend_off = PTR_W'(i);
         end
      end
   end

   assign fill_idx       = rd_ptr + pend_off;
   assign head_rd        = ent[rd_ptr].rd;
   assign head_reg_write = ent[rd_ptr].reg_write;
   assign head_data      = dat[rd_ptr];
   assign next_done      = ent[rd_ptr + PTR_W'(1)].done;

endmodule

// File: rtl/reg_writeback.sv
// Register writeback stage: queues ALU/load results in order and drives the
// register bank write port. Define REG_WB_BYPASS_EN to add the head bypass outputs.
module reg_writeback
   import reg_writeback_pkg::*;
#(
   parameter int XLEN  = 64,
   parameter int DEPTH = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [REG_IDX_W-1:0]  in_rd,
   input  logic                  in_reg_write,
   input  logic                  in_mem_to_reg,
   input  logic [XLEN-1:0]       in_alu_result,
   input  logic                  mem_rsp_valid,
   input  logic [XLEN-1:0]       mem_rsp_data,
   output logic                  wr_en,
   output logic [REG_IDX_W-1:0]  wr_addr,
   output logic [XLEN-1:0]       wr_data,
   output logic                  err_unexp_rsp
`ifdef REG_WB_BYPASS_EN
   ,
   output logic                  byp_valid,
   output logic [REG_IDX_W-1:0]  byp_addr,
   output logic [XLEN-1:0]       byp_data
`endif
);

   // state       | meaning
   // ST_IDLE     | queue empty; an incoming ALU result is written straight through
   // ST_WAIT_MEM | head is a load still waiting for its memory response
   // ST_WRITE    | head is complete and is popped this cycle

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   wb_state_e            state_q, state_d, after_pop;
   wb_entry_t            in_entry;
   logic                 accept, push, pop, fill, wb_fire, wb_we;
   logic [REG_IDX_W-1:0] wb_rd;
   logic [XLEN-1:0]      wb_data;
   logic [CNT_W-1:0]     cnt;
   logic [REG_IDX_W-1:0] head_rd;
   logic                 head_reg_write, next_done, pend_any;
   logic [XLEN-1:0]      head_data;
   logic [PTR_W-1:0]     pend_off;

   assign in_ready = (cnt != CNT_W'(DEPTH));
   assign accept   = in_valid && in_ready;

   assign in_entry.rd         = in_rd;
   assign in_entry.reg_write  = in_reg_write;
   assign in_entry.mem_to_reg = in_mem_to_reg;
   assign in_entry.done       = !in_mem_to_reg;

   // In WAIT_MEM the response belongs to the head, which pops with it directly.
   assign fill = mem_rsp_valid && pend_any && (state_q != ST_WAIT_MEM);

   wb_fifo #(.XLEN(XLEN), .DEPTH(DEPTH)) u_fifo (
      .clk            (clk),
      .rst_n          (rst_n),
      .push           (push),
      .push_entry     (in_entry),
      .push_data      (in_alu_result),
      .pop            (pop),
      .fill           (fill),
      .fill_data      (mem_rsp_data),
      .cnt            (cnt),
      .head_rd        (head_rd),
      .head_reg_write (head_reg_write),
      .head_data      (head_data),
      .next_done      (next_done),
      .pend_any       (pend_any),
      .pend_off       (pend_off)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      push    = 1'b0;
      pop     = 1'b0;
      wb_fire = 1'b0;
      wb_rd   = head_rd;
      wb_we   = head_reg_write;
      wb_data = head_data;

      // What the head looks like once the current head has left
      if (cnt > CNT_W'(1))
         after_pop = (next_done || (fill && (pend_off == PTR_W'(1)))) ? ST_WRITE : ST_WAIT_MEM;
      else if (accept)
         after_pop = in_mem_to_reg ? ST_WAIT_MEM : ST_WRITE;
      else
         after_pop = ST_IDLE;

      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               if (in_mem_to_reg) begin
                  push    = 1'b1;
                  state_d = ST_WAIT_MEM;
               end else begin
                  wb_fire = 1'b1;
                  wb_rd   = in_rd;
                  wb_we   = in_reg_write;
                  wb_data = in_alu_result;
               end
            end
         end
         ST_WAIT_MEM: begin
            push = accept;
            if (mem_rsp_valid) begin
               pop     = 1'b1;
               wb_fire = 1'b1;
               wb_data = mem_rsp_data;
               state_d = after_pop;
            end
         end
         ST_WRITE: begin
            push    = accept;
            pop     = 1'b1;
            wb_fire = 1'b1;
            state_d = after_pop;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_en         <= 1'b0;
         wr_addr       <= '0;
         wr_data       <= '0;
         err_unexp_rsp <= 1'b0;
      end else begin
         wr_en <= wb_fire && wb_we && (wb_rd != '0);
         if (wb_fire && wb_we && (wb_rd != '0)) begin
            wr_addr <= wb_rd;
            wr_data <= wb_data;
         end
         if (mem_rsp_valid && !pend_any) err_unexp_rsp <= 1'b1;
      end
   end

`ifdef REG_WB_BYPASS_EN
   assign byp_valid = (state_q == ST_WRITE) && head_reg_write && (head_rd != '0);
   assign byp_addr  = head_rd;
   assign byp_data  = head_data;
`endif

endmodule

// File: tb/tb_reg_writeback.sv
// Scoreboard bench for reg_writeback: directed latency/boundary cases plus
// randomized ALU/load traffic checked against an in-order request model.
module tb_reg_writeback;

   localparam int XLEN  = 64;
   localparam int DEPTH = 4;
   localparam int NEXP  = 4096;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            in_valid = 1'b0;
   logic            in_ready;
   logic [4:0]      in_rd = '0;
   logic            in_reg_write = 1'b0;
   logic            in_mem_to_reg = 1'b0;
   logic [XLEN-1:0] in_alu_result = '0;
   logic            mem_rsp_valid = 1'b0;
   logic [XLEN-1:0] mem_rsp_data = '0;
   logic            wr_en;
   logic [4:0]      wr_addr;
   logic [XLEN-1:0] wr_data;
   logic            err_unexp_rsp;
`ifdef REG_WB_BYPASS_EN
   logic            byp_valid;
   logic [4:0]      byp_addr;
   logic [XLEN-1:0] byp_data;
`endif

   reg_writeback #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_rd         (in_rd),
      .in_reg_write  (in_reg_write),
      .in_mem_to_reg (in_mem_to_reg),
      .in_alu_result (in_alu_result),
      .mem_rsp_valid (mem_rsp_valid),
      .mem_rsp_data  (mem_rsp_data),
      .wr_en         (wr_en),
      .wr_addr       (wr_addr),
      .wr_data       (wr_data),
      .err_unexp_rsp (err_unexp_rsp)
`ifdef REG_WB_BYPASS_EN
      ,
      .byp_valid     (byp_valid),
      .byp_addr      (byp_addr),
      .byp_data      (byp_data)
`endif
   );

   always #5 clk = ~clk;

   int n_total = 0;
   int n_pass  = 0;

   // Model: every accepted request in program order; loads get data from
   // responses in arrival order.
   logic [4:0]      exp_rd     [NEXP];
   logic [XLEN-1:0] exp_data   [NEXP];
   bit              exp_known  [NEXP];
   bit              exp_writes [NEXP];
   int              exp_head = 0;
   int              exp_tail = 0;
   int              load_q[$];

   task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] req);
      n_total++;
      if (act === req) n_pass++;
      else $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
   endtask

   task automatic drive(input logic v, input logic [4:0] rd, input logic we, input logic m2r,
                        input logic [XLEN-1:0] alu, input logic rv, input logic [XLEN-1:0] rdat);
      @(negedge clk);
      in_valid      = v;
      in_rd         = rd;
      in_reg_write  = we;
      in_mem_to_reg = m2r;
      in_alu_result = alu;
      mem_rsp_valid = rv;
      mem_rsp_data  = rdat;
      if (rv && load_q.size() > 0) begin
         int idx;
         idx = load_q.pop_front();
         exp_data[idx]  = rdat;
         exp_known[idx] = 1'b1;
      end
      if (v && in_ready) begin
         exp_rd[exp_tail]     = rd;
         exp_writes[exp_tail] = we && (rd != 5'd0);
         exp_known[exp_tail]  = !m2r;
         exp_data[exp_tail]   = alu;
         if (m2r) load_q.push_back(exp_tail);
         exp_tail++;
      end
   endtask

   task automatic idle();
      drive(1'b0, 5'd0, 1'b0, 1'b0, '0, 1'b0, '0);
   endtask

   task automatic rsp(input logic [XLEN-1:0] d);
      drive(1'b0, 5'd0, 1'b0, 1'b0, '0, 1'b1, d);
   endtask

   always @(negedge clk) begin
      if (rst_n && wr_en) begin
         while (exp_head < exp_tail && !exp_writes[exp_head]) exp_head++;
         if (exp_head >= exp_tail) begin
            chk("wb_unexpected", {63'd0, wr_en}, '0);
         end else begin
            chk("wb_known", {63'd0, exp_known[exp_head]}, 64'd1);
            chk("wb_addr", {59'd0, wr_addr}, {59'd0, exp_rd[exp_head]});
            chk("wb_data", wr_data, exp_data[exp_head]);
            exp_head++;
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int left;
      repeat (2) @(negedge clk);
      #1;
      chk("rst_wr_en",   {63'd0, wr_en}, '0);
      chk("rst_wr_addr", {59'd0, wr_addr}, '0);
      chk("rst_wr_data", wr_data, '0);
      chk("rst_err",     {63'd0, err_unexp_rsp}, '0);
      @(negedge clk);
      rst_n = 1'b1;
      chk("rst_in_ready", {63'd0, in_ready}, 64'd1);

      // ALU request into an empty queue: write one cycle later
      drive(1'b1, 5'd5, 1'b1, 1'b0, 64'h1234, 1'b0, '0);
      chk("alu_early", {63'd0, wr_en}, '0);
      idle();
      chk("alu_wr_en", {63'd0, wr_en}, 64'd1);
      chk("alu_addr",  {59'd0, wr_addr}, 64'd5);
      chk("alu_data",  wr_data, 64'h1234);

      // Load with late response
      drive(1'b1, 5'd7, 1'b1, 1'b1, 64'h0, 1'b0, '0);
      idle();
      chk("load_wait1", {63'd0, wr_en}, '0);
      idle();
      chk("load_wait2", {63'd0, wr_en}, '0);
      rsp(64'hDEADBEEF);
      chk("load_wait3", {63'd0, wr_en}, '0);
      idle();
      chk("load_wr_en", {63'd0, wr_en}, 64'd1);
      chk("load_addr",  {59'd0, wr_addr}, 64'd7);
      chk("load_data",  wr_data, 64'hDEADBEEF);
      idle();
      chk("load_once", {63'd0, wr_en}, '0);

      // ALU behind a pending load stays in order
      drive(1'b1, 5'd3, 1'b1, 1'b1, 64'h0, 1'b0, '0);
      drive(1'b1, 5'd4, 1'b1, 1'b0, 64'h55, 1'b0, '0);
      idle();
      idle();
      rsp(64'h99);
      idle();
      chk("order1_addr", {59'd0, wr_addr}, 64'd3);
      chk("order1_data", wr_data, 64'h99);
      idle();
      chk("order2_addr", {59'd0, wr_addr}, 64'd4);
      chk("order2_data", wr_data, 64'h55);

      // x0 and non-writing requests drain silently
      drive(1'b1, 5'd0, 1'b1, 1'b0, 64'hFF, 1'b0, '0);
      drive(1'b1, 5'd9, 1'b0, 1'b0, 64'hAA, 1'b0, '0);
      for (int i = 0; i < 3; i++) begin
         idle();
         chk("nowrite_wr_en", {63'd0, wr_en}, '0);
      end
      chk("nowrite_ready", {63'd0, in_ready}, 64'd1);
      chk("nowrite_addr",  {59'd0, wr_addr}, 64'd4);

      // Back-to-back ALU: one write per cycle
      for (int i = 0; i < 8; i++) begin
         drive(1'b1, 5'(i + 1), 1'b1, 1'b0, {$urandom, $urandom}, 1'b0, '0);
         if (i > 0) chk("burst_wr_en", {63'd0, wr_en}, 64'd1);
      end
      idle();
      chk("burst_wr_en", {63'd0, wr_en}, 64'd1);

      // Randomized mixed traffic
      for (int i = 0; i < 400; i++) begin
         logic v, we, m2r, rv;
         v   = ($urandom % 3) != 0;
         we  = ($urandom % 4) != 0;
         m2r = $urandom % 2;
         rv  = (load_q.size() > 0) && (($urandom % 2) == 0);
         drive(v, 5'($urandom), we, m2r, {$urandom, $urandom}, rv, {$urandom, $urandom});
      end
      for (int k = 0; k < 200 && load_q.size() > 0; k++) rsp({$urandom, $urandom});
      repeat (DEPTH + 4) idle();
      left = 0;
      for (int j = exp_head; j < exp_tail; j++) if (exp_writes[j]) left++;
      chk("drain_left",  64'(left), '0);
      chk("drain_ready", {63'd0, in_ready}, 64'd1);
      chk("drain_err",   {63'd0, err_unexp_rsp}, '0);

      // Full queue refuses; stray response sets the sticky error
      for (int i = 0; i < DEPTH; i++) drive(1'b1, 5'(10 + i), 1'b1, 1'b1, '0, 1'b0, '0);
      drive(1'b1, 5'd20, 1'b1, 1'b0, 64'hAB, 1'b0, '0);
      chk("full_ready", {63'd0, in_ready}, '0);
      for (int i = 0; i < DEPTH; i++) rsp(64'h100 + 64'(i));
      repeat (6) idle();
      chk("pre_err", {63'd0, err_unexp_rsp}, '0);
      rsp(64'h5A5A);
      idle();
      chk("unexp_err", {63'd0, err_unexp_rsp}, 64'd1);
      repeat (3) idle();
      chk("unexp_sticky", {63'd0, err_unexp_rsp}, 64'd1);

      // Reset while a load waits
      drive(1'b1, 5'd15, 1'b1, 1'b1, '0, 1'b0, '0);
      idle();
      @(negedge clk);
      rst_n = 1'b0;
      exp_head = exp_tail;
      load_q.delete();
      #1;
      chk("midrst_wr_en",   {63'd0, wr_en}, '0);
      chk("midrst_wr_addr", {59'd0, wr_addr}, '0);
      chk("midrst_wr_data", wr_data, '0);
      chk("midrst_err",     {63'd0, err_unexp_rsp}, '0);
      @(negedge clk);
      rst_n = 1'b1;
      chk("midrst_ready", {63'd0, in_ready}, 64'd1);
      rsp(64'h77);
      idle();
      chk("midrst_err_set", {63'd0, err_unexp_rsp}, 64'd1);
      for (int i = 0; i < 3; i++) begin
         chk("midrst_nowrite", {63'd0, wr_en}, '0);
         idle();
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
